// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush controller for a 5-stage pipeline
// (load-use, taken branch, memory wait with timeout watchdog).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int MAX_WAIT            = 255,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] id_src2,
  input  logic                           id_uses_src1,
  input  logic                           id_uses_src2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] exe_dst,
  input  logic                           exe_is_load,
  input  logic                           exe_reg_wrt_en,
  input  logic                           exe_branch_taken,
  input  logic                           mem_access,
  input  logic                           mem_ready,
  output logic                           pc_en,
  output logic                           if_id_en,
  output logic                           id_exe_en,
  output logic                           exe_mem_en,
  output logic                           mem_wb_en,
  output logic                           if_id_flush,
  output logic                           id_exe_flush,
  output logic                           mem_wb_bubble,
  output logic                           mem_timeout,
  output logic [CNT_WIDTH-1:0]           stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0]           WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       load_use;

  assign mem_stall = mem_access & ~mem_ready;
  assign load_use  = exe_is_load & exe_reg_wrt_en &
                     ((id_uses_src1 & (id_src1 == exe_dst)) |
                      (id_uses_src2 & (id_src2 == exe_dst)));

  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_exe_en     = 1'b0;
    exe_mem_en    = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_timeout   = 1'b0;
    // Reset low forces every control inactive without waiting for a clock.
    if (reset) begin
      if (state == HALT) begin
        mem_timeout = 1'b1;
      end else if (mem_stall) begin
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (exe_branch_taken) begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_exe_en    = 1'b1;
        exe_mem_en   = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (load_use) begin
        id_exe_en    = 1'b1;
        exe_mem_en   = 1'b1;
        mem_wb_en    = 1'b1;
        id_exe_flush = 1'b1;
      end else begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        id_exe_en  = 1'b1;
        exe_mem_en = 1'b1;
        mem_wb_en  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
    end else if (state != HALT) begin
      if (!pc_en && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (mem_stall) begin
        wait_cnt <= wait_cnt + 8'd1;
        state    <= (wait_cnt == WAIT_LAST) ? HALT : MEM_WAIT;
      end else begin
        wait_cnt <= 8'd0;
        state    <= RUN;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed + randomized bench with behavioural model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int MAXW = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    id_src1, id_src2, exe_dst;
  logic          id_uses_src1, id_uses_src2;
  logic          exe_is_load, exe_reg_wrt_en, exe_branch_taken;
  logic          mem_access, mem_ready;
  logic          pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic          if_id_flush, id_exe_flush, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  bit m_halted = 1'b0;
  int m_consec = 0;
  int m_stalls = 0;

  pipeline_hazard_ctrl #(
    .REG_INDEX_BIT_WIDTH(4),
    .MAX_WAIT(MAXW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .exe_dst(exe_dst), .exe_is_load(exe_is_load),
    .exe_reg_wrt_en(exe_reg_wrt_en), .exe_branch_taken(exe_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs from the hazard rules, then advance its state.
  task automatic check_model();
    logic [7:0] exp_o, act_o;
    int  exp_to, exp_cnt;
    bit  ms, lu;
    ms = mem_access && !mem_ready;
    lu = exe_is_load && exe_reg_wrt_en &&
         ((id_uses_src1 && id_src1 == exe_dst) || (id_uses_src2 && id_src2 == exe_dst));
    exp_o   = 8'b0000_0000;
    exp_to  = 0;
    exp_cnt = m_stalls;
    if (!reset)                exp_cnt = 0;
    else if (m_halted)         exp_to = 1;
    else if (ms)               exp_o = 8'b0000_1001;
    else if (exe_branch_taken) exp_o = 8'b1111_1110;
    else if (lu)               exp_o = 8'b0011_1010;
    else                       exp_o = 8'b1111_1000;
    act_o = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
             if_id_flush, id_exe_flush, mem_wb_bubble};
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL model_ctrl: actual=%b required=%b at %0t", act_o, exp_o, $time);
    end
    chk("model_timeout", int'(mem_timeout), exp_to);
    chk("model_stall_cnt", int'(stall_cnt), exp_cnt);
    if (!reset) begin
      m_halted = 1'b0;
      m_consec = 0;
      m_stalls = 0;
    end else if (!m_halted) begin
      if (!exp_o[7]) m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
      if (ms) begin
        m_consec++;
        if (m_consec == MAXW) m_halted = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
  endtask

  task automatic cyc(); @(negedge clk); check_model(); endtask
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic tick(); cyc(); nxt(); endtask

  task automatic idle();
    id_src1 = 4'd1; id_src2 = 4'd2; exe_dst = 4'd7;
    id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
    exe_is_load = 1'b0; exe_reg_wrt_en = 1'b0; exe_branch_taken = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_load_use();
    exe_is_load = 1'b1; exe_reg_wrt_en = 1'b1; exe_dst = 4'd3;
    id_src1 = 4'd5; id_uses_src1 = 1'b1;
    id_src2 = 4'd3; id_uses_src2 = 1'b1;
  endtask

  task automatic reset_pulse();
    reset = 1'b0; cyc();
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_pc_en", int'(pc_en), 0);
    nxt(); reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    cyc();
    chk("reset_pc_en", int'(pc_en), 0);
    chk("reset_mem_wb_en", int'(mem_wb_en), 0);
    chk("reset_timeout", int'(mem_timeout), 0);
    nxt();
    reset = 1'b1;

    // Hazard-free run after reset release.
    cyc();
    chk("run_pc_en", int'(pc_en), 1);
    chk("run_if_id_flush", int'(if_id_flush), 0);
    nxt();
    for (int i = 0; i < 9; i++) tick();
    cyc();
    chk("run_stall_cnt", int'(stall_cnt), 0);
    nxt();

    // Load-use: one bubble cycle.
    set_load_use();
    cyc();
    chk("lu_pc_en", int'(pc_en), 0);
    chk("lu_if_id_en", int'(if_id_en), 0);
    chk("lu_id_exe_flush", int'(id_exe_flush), 1);
    nxt();
    idle();
    cyc();
    chk("lu_after_stall_cnt", int'(stall_cnt), 1);
    chk("lu_after_pc_en", int'(pc_en), 1);
    nxt();

    // Branch squashes a simultaneous load-use.
    set_load_use();
    exe_branch_taken = 1'b1;
    cyc();
    chk("br_if_id_flush", int'(if_id_flush), 1);
    chk("br_id_exe_flush", int'(id_exe_flush), 1);
    chk("br_pc_en", int'(pc_en), 1);
    nxt();
    idle();
    cyc();
    chk("br_after_stall_cnt", int'(stall_cnt), 1);
    nxt();

    // Back-to-back load-use then branch.
    set_load_use();
    cyc();
    chk("b2b_lu_pc_en", int'(pc_en), 0);
    nxt();
    idle();
    exe_branch_taken = 1'b1;
    cyc();
    chk("b2b_br_flush", int'(if_id_flush), 1);
    chk("b2b_br_pc_en", int'(pc_en), 1);
    nxt();
    idle();

    // 3-cycle memory wait with a pending branch.
    reset_pulse();
    mem_access = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mw_bubble", int'(mem_wb_bubble), 1);
      chk("mw_pc_en", int'(pc_en), 0);
      chk("mw_if_id_flush", int'(if_id_flush), 0);
      nxt();
    end
    mem_ready = 1'b1;
    cyc();
    chk("mw_branch_flush", int'(if_id_flush), 1);
    chk("mw_stall_cnt", int'(stall_cnt), 3);
    nxt();
    idle();

    // Timeout: ready held low.
    reset_pulse();
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MAXW; i++) tick();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halt_timeout", int'(mem_timeout), 1);
      chk("halt_mem_wb_en", int'(mem_wb_en), 0);
      chk("halt_stall_cnt", int'(stall_cnt), MAXW);
      nxt();
    end
    reset = 1'b0;
    #1;
    chk("halt_async_timeout", int'(mem_timeout), 0);
    chk("halt_async_stall_cnt", int'(stall_cnt), 0);
    cyc();
    nxt();
    reset = 1'b1;
    idle();

    // Ready arrives on the last permitted stall cycle.
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MAXW - 1; i++) tick();
    mem_ready = 1'b1;
    cyc();
    chk("late_ready_timeout", int'(mem_timeout), 0);
    chk("late_ready_pc_en", int'(pc_en), 1);
    nxt();
    idle();
    cyc();
    chk("late_ready_after", int'(mem_timeout), 0);
    nxt();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 199) != 0);
      id_src1          = 4'($urandom_range(0, 3));
      id_src2          = 4'($urandom_range(0, 3));
      exe_dst          = 4'($urandom_range(0, 3));
      id_uses_src1     = 1'($urandom_range(0, 1));
      id_uses_src2     = 1'($urandom_range(0, 1));
      exe_is_load      = ($urandom_range(0, 2) != 0);
      exe_reg_wrt_en   = ($urandom_range(0, 3) != 0);
      exe_branch_taken = ($urandom_range(0, 4) == 0);
      mem_access       = ($urandom_range(0, 1) == 0);
      mem_ready        = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipelined CPU. It drives the enable inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB buffers and the PC register, and the flush/bubble controls on those buffers. It resolves three conditions:
- load-use hazards;
- taken-branch squashes;
- multi-cycle data-memory waits, with a watchdog that halts the pipeline on a memory timeout.

## Interface
Parameters:
- REG_INDEX_BIT_WIDTH, 4, register index width
- MAX_WAIT, 255, maximum consecutive memory-wait cycles before halt (legal range 1..255)
- CNT_WIDTH, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- id_src1, id_src2  in  REG_INDEX_BIT_WIDTH  source indices of the instruction in ID
- id_uses_src1, id_uses_src2  in  1  the ID instruction actually reads that source
- exe_dst  in  REG_INDEX_BIT_WIDTH  destination index of the instruction in EXE
- exe_is_load  in  1  the EXE instruction is a load
- exe_reg_wrt_en  in  1  the EXE instruction writes the register file
- exe_branch_taken  in  1  the EXE instruction resolved as a taken branch/jump
- mem_access  in  1  the MEM-stage instruction performs a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1  register/buffer enables
- if_id_flush, id_exe_flush  out  1  load a NOP into that buffer on the next edge (overrides the buffer's data)
- mem_wb_bubble  out  1  MEM/WB captures a NOP instead of MEM results
- mem_timeout  out  1  sticky error; pipeline halted
- stall_cnt  out  CNT_WIDTH  saturating count of cycles with pc_en = 0, excluding HALT

## Operation
- FSM states: RUN, MEM_WAIT, HALT. All outputs are combinational from the state, the registered counters and the inputs.
- Derived conditions:
  - mem_stall = mem_access & !mem_ready.
  - load_use = exe_is_load & exe_reg_wrt_en & ((id_uses_src1 & id_src1 == exe_dst) | (id_uses_src2 & id_src2 == exe_dst)). Register index 0 is not special.
- Priority in RUN/MEM_WAIT: mem_stall > exe_branch_taken > load_use > normal.
- Normal operation:
  - All five enables are 1.
  - All flush/bubble outputs are 0.
- mem_stall:
  - pc_en = if_id_en = id_exe_en = exe_mem_en = 0.
  - mem_wb_en = 1 and mem_wb_bubble = 1.
  - All other flushes are 0.
  - Because ID/EXE is frozen, a pending branch or load-use condition is held and handled on the first non-stalled cycle.
- exe_branch_taken:
  - All enables are 1.
  - if_id_flush = id_exe_flush = 1, for exactly one cycle per branch. The branch leaves EXE on that edge.
  - load_use is ignored, because the ID instruction is squashed.
- load_use:
  - pc_en = if_id_en = 0.
  - id_exe_en = 1 and id_exe_flush = 1 (bubble into EXE).
  - exe_mem_en = mem_wb_en = 1.
  - The stall lasts one cycle; the load then advances to MEM and the condition clears.
- State transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN when mem_ready = 1.
  - RUN/MEM_WAIT→HALT when mem_stall holds and wait_cnt == MAX_WAIT-1.
  - HALT is left only by reset.
- wait_cnt (internal, 8 bits):
  - Increments on every mem_stall cycle.
  - Clears on any non-stall cycle.
  - Therefore HALT is entered after exactly MAX_WAIT consecutive stalled cycles.
  - If mem_ready = 1 in the cycle wait_cnt reaches MAX_WAIT-1, ready wins: no halt.
- HALT:
  - All enables are 0.
  - All flushes and mem_wb_bubble are 0.
  - mem_timeout = 1.
  - stall_cnt is frozen.
- stall_cnt:
  - +1 on every cycle in RUN/MEM_WAIT with pc_en = 0.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.

## Timing
- While reset = 0:
  - State is RUN; wait_cnt = 0, stall_cnt = 0, mem_timeout = 0.
  - All enables and flushes are forced to 0, independent of the clock.
- On the first edge after reset release, outputs follow the RUN rules.
- Decision latency is 0 cycles: outputs respond combinationally to the stage inputs of the current cycle. State and counters update on the next rising edge.
- mem_timeout is asserted in the cycle after the MAX_WAIT-th consecutive stalled cycle.
- A reset asserted mid-stall or in HALT returns to RUN with counters cleared immediately (asynchronously).
- A back-to-back load-use followed by a branch in the next cycle produces one bubble cycle, then one flush cycle; the stall and the flush never combine in the same cycle.

## Test plan
- Reset release, no hazards:
  - Required: all enables 1 and flushes 0 from the first cycle.
  - Required: stall_cnt stays 0 for 10 cycles.
- Load-use: exe_is_load=1, exe_reg_wrt_en=1, exe_dst=3, id_src2=3, id_uses_src2=1.
  - Required: one cycle with pc_en=if_id_en=0, id_exe_flush=1.
  - Required: stall_cnt=1; normal operation on the next cycle.
- Taken branch with an ID load-use condition also present:
  - Required: if_id_flush=id_exe_flush=1 and all enables 1 for one cycle.
  - Required: no stall; stall_cnt unchanged.
- Memory wait of 3 cycles (mem_access=1, mem_ready low 3 cycles then high) with exe_branch_taken=1 held:
  - Required: 3 cycles of frozen front end with mem_wb_bubble=1.
  - Required: then the flush cycle; stall_cnt=3.
- MAX_WAIT=4, mem_ready held low:
  - Required: after 4 stalled cycles, state HALT, mem_timeout=1, all enables 0.
  - Required: stall_cnt=4; HALT persists until reset goes low, after which everything clears immediately.
- MAX_WAIT=4, mem_ready rises in the 4th stalled cycle:
  - Required: no halt, mem_timeout=0, return to RUN.
